// File: rtl/floor_request_arbiter.sv
// Elevator floor-request arbiter: synchronizes and debounces five floor buttons,
// keeps the set of outstanding requests and picks the next floor with an UP/DOWN sweep.
module floor_request_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] buttons_i,
  input  logic [2:0] cur_floor_i,
  input  logic       arrived_i,
  output logic [4:0] pending_o,
  output logic [2:0] target_floor_o,
  output logic       target_valid_o,
  output logic       dir_up_o
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] DEB_PRE = 4'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_e;

  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic [4:0] accept;
  logic [4:0] cur_hit;
  logic [4:0] clear_mask;
  logic [4:0] above;
  logic [4:0] below;
  logic [4:0] pending_q;
  logic [4:0] pending_d;

  state_e     state_q;
  state_e     state_d;
  logic [2:0] target_q;
  logic [2:0] target_d;
  logic       valid_q;
  logic       valid_d;
  logic       dir_up_q;
  logic       dir_up_d;

  logic       any_above;
  logic       any_below;
  logic       here_pending;
  logic [2:0] lowest_above;
  logic [2:0] highest_below;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_floor
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       fire_q;
    logic       fire_d;

    // fire_q is high exactly in the one cycle where cnt_q first equals DEB_MAX;
    // the saturating counter then keeps it from firing again until release.
    always_comb begin
      cnt_d  = 4'd0;
      fire_d = 1'b0;
      if (sync2_q[gi]) begin
        cnt_d  = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 4'd1;
        fire_d = (cnt_q == DEB_PRE);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= 4'd0;
        fire_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        fire_q <= fire_d;
      end
    end

    assign accept[gi]     = fire_q;
    assign cur_hit[gi]    = (cur_floor_i == 3'(gi));
    assign clear_mask[gi] = arrived_i && cur_hit[gi];
    assign above[gi]      = pending_q[gi] && (3'(gi) > cur_floor_i);
    assign below[gi]      = pending_q[gi] && (3'(gi) < cur_floor_i);
  end

  // Clear dominates a coincident acceptance; an out-of-range floor hits no bit.
  assign pending_d = (pending_q | accept) & ~clear_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign any_above    = |above;
  assign any_below    = |below;
  assign here_pending = |(pending_q & cur_hit);

  always_comb begin
    lowest_above  = 3'd0;
    highest_below = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (above[i]) lowest_above = 3'(i);
    end
    for (int i = 0; i < 5; i++) begin
      if (below[i]) highest_below = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    valid_d  = valid_q;
    dir_up_d = dir_up_q;
    if (cur_floor_i <= 3'd4) begin
      case (state_q)
        S_IDLE: begin
          if (any_above)      state_d = S_UP;
          else if (any_below) state_d = S_DOWN;
          else                state_d = S_IDLE;
        end
        S_UP: begin
          if (any_above)      state_d = S_UP;
          else if (any_below) state_d = S_DOWN;
          else                state_d = S_IDLE;
        end
        S_DOWN: begin
          if (any_below)      state_d = S_DOWN;
          else if (any_above) state_d = S_UP;
          else                state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      case (state_d)
        S_UP: begin
          target_d = lowest_above;
          valid_d  = 1'b1;
        end
        S_DOWN: begin
          target_d = highest_below;
          valid_d  = 1'b1;
        end
        default: begin
          if (here_pending) target_d = cur_floor_i;
          valid_d = here_pending;
        end
      endcase
      dir_up_d = (state_d == S_UP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= 3'd0;
      valid_q  <= 1'b0;
      dir_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign pending_o      = pending_q;
  assign target_floor_o = target_q;
  assign target_valid_o = valid_q;
  assign dir_up_o       = dir_up_q;

endmodule

// File: tb/tb_floor_request_arbiter.sv
// Scoreboard bench for floor_request_arbiter: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_floor_request_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:0] buttons;
  logic [2:0] cur_floor;
  logic       arrived;
  logic [4:0] pending;
  logic [2:0] target_floor;
  logic       target_valid;
  logic       dir_up;

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] pend;
    logic [2:0] tf;
    logic       tv;
    logic       du;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc;
  int   checks;
  int   errors;

  floor_request_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .buttons_i      (buttons),
    .cur_floor_i    (cur_floor),
    .arrived_i      (arrived),
    .pending_o      (pending),
    .target_floor_o (target_floor),
    .target_valid_o (target_valid),
    .dir_up_o       (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [4:0] p, input logic [2:0] tf,
                       input logic tv, input logic du);
    checks++;
    if ({pending, target_floor, target_valid, dir_up} !== {p, tf, tv, du}) begin
      errors++;
      $display("FAIL %s @cyc %0d: got pending=%b target=%0d valid=%b dir_up=%b, want pending=%b target=%0d valid=%b dir_up=%b",
               name, cyc, pending, target_floor, target_valid, dir_up, p, tf, tv, du);
    end else begin
      $display("ok   %s @cyc %0d: pending=%b target=%0d valid=%b dir_up=%b",
               name, cyc, pending, target_floor, target_valid, dir_up);
    end
  endtask

  function automatic void expect_at(input int dc, input string name, input logic [4:0] p,
                                    input logic [2:0] tf, input logic tv, input logic du);
    exp_t e;
    e.cyc  = cyc + dc;
    e.name = name;
    e.pend = p;
    e.tf   = tf;
    e.tv   = tv;
    e.du   = du;
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d missed, now cyc %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        check(mon_e.name, mon_e.pend, mon_e.tf, mon_e.tv, mon_e.du);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    buttons   = 5'b00000;
    cur_floor = 3'd0;
    arrived   = 1'b0;

    tick(1);
    expect_at(0, "reset_state", 5'b00000, 3'd0, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single press at floor 2 from floor 0: pending at +7, UP/target 2 at +8
    buttons = 5'b00100;
    expect_at(6, "press2_not_yet", 5'b00000, 3'd0, 1'b0, 1'b0);
    expect_at(7, "press2_pending", 5'b00100, 3'd0, 1'b0, 1'b0);
    expect_at(8, "press2_up",      5'b00100, 3'd2, 1'b1, 1'b1);
    tick(10);
    buttons = 5'b00000;

    // Arrive at floor 2: clear, IDLE with target 2 valid, then target held, invalid
    cur_floor = 3'd2;
    arrived   = 1'b1;
    expect_at(1, "arrive2_idle_here", 5'b00000, 3'd2, 1'b1, 1'b0);
    tick(1);
    arrived = 1'b0;
    expect_at(1, "arrive2_hold_tgt", 5'b00000, 3'd2, 1'b0, 1'b0);
    tick(2);

    // Two-cycle glitch on floor 3 is rejected
    buttons = 5'b01000;
    expect_at(10, "glitch_rejected", 5'b00000, 3'd2, 1'b0, 1'b0);
    tick(2);
    buttons = 5'b00000;
    tick(10);

    // Floors 4 and 0 from floor 2: UP toward 4, then arrive at 4 -> DOWN toward 0
    buttons = 5'b10001;
    expect_at(7, "p10001_pending", 5'b10001, 3'd2, 1'b0, 1'b0);
    expect_at(8, "p10001_up_tgt4", 5'b10001, 3'd4, 1'b1, 1'b1);
    tick(8);
    buttons   = 5'b00000;
    cur_floor = 3'd4;
    arrived   = 1'b1;
    expect_at(1, "arrive4_down_tgt0", 5'b00001, 3'd0, 1'b1, 1'b0);
    tick(1);
    arrived = 1'b0;
    expect_at(1, "down_stays", 5'b00001, 3'd0, 1'b1, 1'b0);
    tick(2);

    // Acceptance of floor 1 coincides with arrival at floor 1: clear wins
    cur_floor = 3'd1;
    buttons   = 5'b00010;
    tick(6);
    arrived = 1'b1;
    expect_at(1, "accept_vs_clear", 5'b00001, 3'd0, 1'b1, 1'b0);
    tick(1);
    arrived = 1'b0;
    expect_at(1, "clear_still_wins", 5'b00001, 3'd0, 1'b1, 1'b0);
    tick(2);
    buttons = 5'b00000;
    tick(1);

    // Arrive at floor 0: DOWN ends, IDLE shows floor 0 once, then idle invalid
    cur_floor = 3'd0;
    arrived   = 1'b1;
    expect_at(1, "arrive0_idle_here", 5'b00000, 3'd0, 1'b1, 1'b0);
    tick(1);
    arrived = 1'b0;
    expect_at(1, "idle_empty", 5'b00000, 3'd0, 1'b0, 1'b0);
    tick(1);

    // Floor 3 request, then invalid cur_floor=6 with arrived: nothing changes
    buttons = 5'b01000;
    expect_at(8, "p01000_up_tgt3", 5'b01000, 3'd3, 1'b1, 1'b1);
    tick(8);
    buttons   = 5'b00000;
    cur_floor = 3'd6;
    arrived   = 1'b1;
    expect_at(1, "bad_floor_ignored", 5'b01000, 3'd3, 1'b1, 1'b1);
    tick(1);
    arrived = 1'b0;
    expect_at(3, "bad_floor_hold", 5'b01000, 3'd3, 1'b1, 1'b1);
    tick(4);
    cur_floor = 3'd0;
    tick(1);

    // From floor 4 the floor-3 request is below: DOWN toward 3
    cur_floor = 3'd4;
    expect_at(1, "up_to_down_tgt3", 5'b01000, 3'd3, 1'b1, 1'b0);
    tick(1);
    buttons = 5'b10010;
    expect_at(8, "p11010_down_tgt3", 5'b11010, 3'd3, 1'b1, 1'b0);
    tick(8);

    // Asynchronous reset mid-operation, checked before any clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 5'b00000, 3'd0, 1'b0, 1'b0);
    expect_at(0, "reset_hold", 5'b00000, 3'd0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;

    // Buttons still held across release need the full latency again
    expect_at(6, "held_not_yet", 5'b00000, 3'd0, 1'b0, 1'b0);
    expect_at(7, "held_pending",  5'b10010, 3'd0, 1'b0, 1'b0);
    expect_at(8, "held_down_tgt1", 5'b10010, 3'd1, 1'b1, 1'b0);
    tick(10);
    buttons = 5'b00000;
    tick(2);

    guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
